uart_rx_deserializer: RTL

- UART 8N1 receiver, directly upstream of the UART ring buffer.
- Synchronises the serial line, finds start bits, samples each bit at mid-bit and checks the stop bit.
- Emits each good byte with a one-cycle strobe; dataOut/dataValid connect straight to the ring buffer's data/writeEnable.
- Uses the same bit-length parameter as the ring buffer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_bit.sv | 27 ++
 rtl/uart_rx_deserializer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   rx_state_t      : receiver frame-tracking states
//   UART_DATA_BITS  : payload bits per frame (8N1)
//   halfBit()       : mid-bit offset, in clocks, for start-bit sampling
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;

  // Clocks from the detected falling edge to the middle of the start bit.
  function automatic int unsigned halfBit(input int unsigned bitLength);
    return bitLength / 2 - 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Generic two-flop synchroniser for a single asynchronous bit.
//   clk   : destination clock
//   reset : asynchronous active-high reset, loads RESET_VALUE into both flops
//   d     : asynchronous input
//   q     : synchronised output, two clocks behind d
module sync_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RESET_VALUE;
      q  <= RESET_VALUE;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver feeding the UART ring buffer.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   rxIn       : raw serial line, idles high
//   dataOut    : last correctly received byte
//   dataValid  : one-cycle strobe, dataOut valid in the same cycle
//   frameError : one-cycle strobe when the stop bit is sampled low
//   busy       : high while a frame is in progress
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned BITLENGTH = 868
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rxIn,
  output logic [UART_DATA_BITS-1:0] dataOut,
  output logic                      dataValid,
  output logic                      frameError,
  output logic                      busy
);

  localparam int unsigned HALFBIT = halfBit(BITLENGTH);
  localparam int unsigned TIMER_W = $clog2(BITLENGTH);
  localparam logic [TIMER_W-1:0] HALF_T   = TIMER_W'(HALFBIT);
  localparam logic [TIMER_W-1:0] LAST_T   = TIMER_W'(BITLENGTH - 1);
  localparam logic [2:0]         LAST_IDX = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state, state_nx;
  logic [TIMER_W-1:0]        bit_timer, timer_nx;
  logic [2:0]                bit_index, index_nx;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_nx;
  logic [UART_DATA_BITS-1:0] data_nx;
  logic                      valid_nx, ferr_nx, busy_nx;
  logic                      sync_rx;

  sync_bit #(
    .RESET_VALUE(1'b0)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rxIn),
    .q    (sync_rx)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_IDLE;
      bit_timer  <= '0;
      bit_index  <= '0;
      shift_reg  <= '0;
      dataOut    <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_timer  <= timer_nx;
      bit_index  <= index_nx;
      shift_reg  <= shift_nx;
      dataOut    <= data_nx;
      dataValid  <= valid_nx;
      frameError <= ferr_nx;
      busy       <= busy_nx;
    end
  end

  // Frame tracking: next state, counters, shift register and strobes.
  always_comb begin
    state_nx = state;
    timer_nx = bit_timer;
    index_nx = bit_index;
    shift_nx = shift_reg;
    data_nx  = dataOut;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;

    case (state)
      // Line must be seen high before a falling edge can count as a start bit.
      WAIT_IDLE: begin
        if (sync_rx) state_nx = IDLE;
      end
      IDLE: begin
        if (!sync_rx) begin
          state_nx = START;
          timer_nx = '0;
        end
      end
      // Re-check the line at mid start bit; a high level means a glitch.
      START: begin
        if (bit_timer == HALF_T) begin
          timer_nx = '0;
          if (!sync_rx) begin
            state_nx = DATA;
            index_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          timer_nx = bit_timer + 1'b1;
        end
      end
      // Timer is already at mid-bit, so each full period lands mid data bit.
      DATA: begin
        if (bit_timer == LAST_T) begin
          shift_nx = {sync_rx, shift_reg[UART_DATA_BITS-1:1]};
          timer_nx = '0;
          index_nx = bit_index + 1'b1;
          if (bit_index == LAST_IDX) state_nx = STOP;
        end else begin
          timer_nx = bit_timer + 1'b1;
        end
      end
      STOP: begin
        if (bit_timer == LAST_T) begin
          timer_nx = '0;
          if (sync_rx) begin
            data_nx  = shift_reg;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end else begin
          timer_nx = bit_timer + 1'b1;
        end
      end
      default: state_nx = WAIT_IDLE;
    endcase

    busy_nx = (state_nx == START) || (state_nx == DATA) || (state_nx == STOP);
  end

endmodule
